// File: rtl/stbuf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stbuf_pkg: shared types and helpers for store_buffer (size enum, FSM       |
// | states, entry struct, byte-enable and lane-replication functions).         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package stbuf_pkg;

   // Entries hold a fixed-width address so the struct is usable for any AW up to this.
   localparam int STBUF_MAX_AW = 64;

   typedef enum logic [1:0] {
      ST_NONE = 2'd0,
      ST_WORD = 2'd1,
      ST_HALF = 2'd2,
      ST_BYTE = 2'd3
   } st_size_e;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_FENCE = 2'd1,
      S_DONE  = 2'd2
   } stbuf_state_e;

   typedef struct packed {
      logic [STBUF_MAX_AW-1:0] addr;
      logic [31:0]             data;
      st_size_e                size;
   } stbuf_entry_t;

   function automatic logic [3:0] be_gen(input st_size_e size, input logic [1:0] a);
      logic [3:0] be;
      case (size)
         ST_WORD: be = 4'b1111;
         ST_HALF: be = a[1] ? 4'b1100 : 4'b0011;
         ST_BYTE: be = 4'b0001 << a;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] lane_rep(input st_size_e size, input logic [31:0] d);
      logic [31:0] r;
      case (size)
         ST_WORD: r = d;
         ST_HALF: r = {2{d[15:0]}};
         ST_BYTE: r = {4{d[7:0]}};
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   function automatic logic addr_aligned(input st_size_e size, input logic [1:0] a);
      logic ok;
      case (size)
         ST_WORD: ok = (a == 2'b00);
         ST_HALF: ok = ~a[0];
         ST_BYTE: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage
`default_nettype wire

// File: rtl/stbuf_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | stbuf_fifo: in-order entry FIFO with full/empty, count, and a flat view    |
// | of all storage slots. DEPTH must be a power of two, at least 2.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module stbuf_fifo
   import stbuf_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      push,
   input  logic                      pop,
   input  stbuf_entry_t              wr_entry,
   output stbuf_entry_t              head,
   output logic                      full,
   output logic                      empty,
   output logic [CW-1:0]             count,
   output logic [PW-1:0]             rd_ptr,
   output stbuf_entry_t [DEPTH-1:0]  entries
);

   stbuf_entry_t [DEPTH-1:0] mem_q, mem_d;
   logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]            count_q, count_d;
   logic                     push_ok, pop_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = wr_entry;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
         count_d = count_q - 1'b1;
      end
   end

   // Storage is cleared too so head-derived outputs read zero out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head    = mem_q[rd_ptr_q];
   assign count   = count_q;
   assign rd_ptr  = rd_ptr_q;
   assign entries = mem_q;

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | store_buffer: posted-write FIFO between core data port and slow memory,    |
// | with fence handling. Define STBUF_FWD_EN for store-to-load forwarding.     |
// | AW must not exceed 64. Revision: 1.0                                       |
// +----------------------------------------------------------------------------+
module store_buffer
   import stbuf_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [1:0]    memwrite,
   input  logic [AW-1:0] dataadr,
   input  logic [31:0]   writedata,
   input  logic          fence,
   output logic          stall,
   output logic          misalign,
   output logic          fence_done,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic [3:0]    mem_be,
   input  logic          mem_ack
`ifdef STBUF_FWD_EN
   ,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_hit,
   output logic [31:0]   rd_data,
   output logic          rd_conflict
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   stbuf_state_e             state_q, state_d;
   logic                     misalign_q, misalign_d;
   st_size_e                 st_size;
   logic                     store_req, is_aligned, push, pop, full, empty;
   stbuf_entry_t             wr_entry, head;
   stbuf_entry_t [DEPTH-1:0] entries;
   logic [CW-1:0]            count;
   logic [PW-1:0]            rd_ptr;
   logic                     unused_bits;

   assign st_size    = st_size_e'(memwrite);
   assign store_req  = (memwrite != 2'b00);
   assign is_aligned = addr_aligned(st_size, dataadr[1:0]);
   assign wr_entry   = '{addr: STBUF_MAX_AW'(dataadr), data: writedata, size: st_size};
   assign push       = store_req && is_aligned && !full && (state_q == S_RUN);
   assign pop        = mem_req && mem_ack;

   stbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pop      (pop),
      .wr_entry (wr_entry),
      .head     (head),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .rd_ptr   (rd_ptr),
      .entries  (entries)
   );

   assign mem_req   = !empty;
   assign mem_addr  = head.addr[AW-1:0];
   assign mem_wdata = lane_rep(head.size, head.data);
   assign mem_be    = be_gen(head.size, head.addr[1:0]);
   assign stall     = (store_req && is_aligned && full) || (state_q == S_FENCE);

   assign misalign_d = store_req && !is_aligned;
   assign misalign   = misalign_q;

   always_comb begin
      state_d    = state_q;
      fence_done = 1'b0;
      case (state_q)
         S_RUN:   if (fence) state_d = S_FENCE;
         S_FENCE: if (count == '0) begin
                     fence_done = 1'b1;
                     state_d    = S_DONE;
                  end
         S_DONE:  if (!fence) state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_RUN;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         misalign_q <= misalign_d;
      end
   end

`ifdef STBUF_FWD_EN
   stbuf_entry_t fwd_e;

   // Walk oldest to youngest so the youngest matching entry overrides earlier ones.
   always_comb begin
      rd_hit      = 1'b0;
      rd_conflict = 1'b0;
      rd_data     = 32'h0;
      fwd_e       = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (k < int'(count)) begin
            fwd_e = entries[rd_ptr + PW'(k)];
            if (fwd_e.addr[AW-1:2] == rd_addr[AW-1:2]) begin
               rd_hit      = (fwd_e.size == ST_WORD);
               rd_conflict = (fwd_e.size != ST_WORD);
               rd_data     = (fwd_e.size == ST_WORD) ? fwd_e.data : 32'h0;
            end
         end
      end
   end

   assign unused_bits = ^{head.addr, fwd_e, rd_addr[1:0]};
`else
   assign unused_bits = ^{head.addr, entries, rd_ptr};
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_store_buffer: directed self-checking bench for store_buffer.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    memwrite;
   logic [AW-1:0] dataadr;
   logic [31:0]   writedata;
   logic          fence;
   logic          stall, misalign, fence_done, mem_req, mem_ack;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_be;
`ifdef STBUF_FWD_EN
   logic [AW-1:0] rd_addr;
   logic          rd_hit, rd_conflict;
   logic [31:0]   rd_data;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   store_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .memwrite   (memwrite),
      .dataadr    (dataadr),
      .writedata  (writedata),
      .fence      (fence),
      .stall      (stall),
      .misalign   (misalign),
      .fence_done (fence_done),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_ack    (mem_ack)
`ifdef STBUF_FWD_EN
      ,
      .rd_addr    (rd_addr),
      .rd_hit     (rd_hit),
      .rd_data    (rd_data),
      .rd_conflict(rd_conflict)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({stall, misalign, fence_done, mem_req} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {stall, misalign, fence_done, mem_req}); end
      checks++; if (mem_be !== 4'h0) begin errors++; $display("FAIL reset_be: got %h want 0", mem_be); end
      checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin errors++; $display("FAIL reset_addr_data: got %h/%h want 0/0", mem_addr, mem_wdata); end
`ifdef STBUF_FWD_EN
      checks++; if ({rd_hit, rd_conflict, rd_data} !== 34'h0) begin errors++; $display("FAIL reset_fwd: got %b/%b/%h want 0", rd_hit, rd_conflict, rd_data); end
`endif
      reset = 1'b0;
      step();
   endtask

   task automatic test_word_store();
      mem_ack = 1'b1; memwrite = 2'b01; dataadr = 32'd84; writedata = 32'hFFFF7F02;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL word_stall: got %b want 0", stall); end
      step();
      memwrite = 2'b00;
      #1;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL word_req: got %b want 1", mem_req); end
      checks++; if (mem_addr !== 32'd84) begin errors++; $display("FAIL word_addr: got %h want 54", mem_addr); end
      checks++; if (mem_be !== 4'b1111) begin errors++; $display("FAIL word_be: got %b want 1111", mem_be); end
      checks++; if (mem_wdata !== 32'hFFFF7F02) begin errors++; $display("FAIL word_wdata: got %h want FFFF7F02", mem_wdata); end
      step();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL word_popped: got %b want 0", mem_req); end
   endtask

   task automatic test_sizes();
      mem_ack = 1'b1; memwrite = 2'b11; dataadr = 32'h13; writedata = 32'h0000005A;
      step();
      memwrite = 2'b10; dataadr = 32'h22; writedata = 32'h00001234;
      #1;
      checks++; if (mem_be !== 4'b1000) begin errors++; $display("FAIL byte_be: got %b want 1000", mem_be); end
      checks++; if (mem_wdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL byte_wdata: got %h want 5A5A5A5A", mem_wdata); end
      step();
      memwrite = 2'b00;
      #1;
      checks++; if (mem_be !== 4'b1100) begin errors++; $display("FAIL half_be: got %b want 1100", mem_be); end
      checks++; if (mem_wdata !== 32'h12341234) begin errors++; $display("FAIL half_wdata: got %h want 12341234", mem_wdata); end
      checks++; if (mem_addr !== 32'h22) begin errors++; $display("FAIL half_addr: got %h want 22", mem_addr); end
      step();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL sizes_drained: got %b want 0", mem_req); end
   endtask

   task automatic test_full();
      mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         memwrite = 2'b01; dataadr = 32'h100 + 32'(4 * i); writedata = 32'hA0 + 32'(i);
         #1;
         checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fill_stall_%0d: got %b want 0", i, stall); end
         step();
      end
      dataadr = 32'h110; writedata = 32'hA4;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b want 1", stall); end
      checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL full_head: got %h want 100", mem_addr); end
      step();
      mem_ack = 1'b1;
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_no_bypass: got %b want 1", stall); end
      step();
      mem_ack = 1'b0;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL after_pop_stall: got %b want 0", stall); end
      checks++; if (mem_addr !== 32'h104) begin errors++; $display("FAIL after_pop_head: got %h want 104", mem_addr); end
      step();
      memwrite = 2'b00; mem_ack = 1'b1;
      for (int j = 1; j < 5; j++) begin
         #1;
         checks++; if (mem_addr !== 32'h100 + 32'(4 * j) || mem_wdata !== 32'hA0 + 32'(j)) begin errors++; $display("FAIL drain_order_%0d: got %h/%h want %h/%h", j, mem_addr, mem_wdata, 32'h100 + 32'(4 * j), 32'hA0 + 32'(j)); end
         step();
      end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_drained: got %b want 0", mem_req); end
   endtask

   task automatic test_misalign();
      mem_ack = 1'b1; memwrite = 2'b01; dataadr = 32'h42; writedata = 32'hDEAD;
      #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL misalign_stall: got %b want 0", stall); end
      step();
      memwrite = 2'b00;
      #1;
      checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misalign_pulse: got %b want 1", misalign); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL misalign_dropped: got %b want 0", mem_req); end
      step();
      checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL misalign_clear: got %b want 0", misalign); end
   endtask

   task automatic test_fence();
      int done_at;
      int extra;
      done_at = -1; extra = 0;
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         memwrite = 2'b01; dataadr = 32'h200 + 32'(4 * i); writedata = 32'(i);
         step();
      end
      memwrite = 2'b00; fence = 1'b1;
      step();
      // Pops land at the edges closing cycles 2, 5 and 8, so completion is in cycle 9.
      for (int c = 0; c < 30 && done_at < 0; c++) begin
         mem_ack = (c % 3 == 2);
         #1;
         checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fence_stall_c%0d: got %b want 1", c, stall); end
         if (fence_done === 1'b1) done_at = c;
         step();
      end
      mem_ack = 1'b0;
      checks++; if (done_at != 9) begin errors++; $display("FAIL fence_done_cycle: got %0d want 9", done_at); end
      for (int c = 0; c < 2; c++) begin
         if (fence_done === 1'b1) extra++;
         step();
      end
      checks++; if (extra != 0) begin errors++; $display("FAIL fence_done_once: got %0d extra pulses want 0", extra); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fence_done_stall: got %b want 0", stall); end
      fence = 1'b0;
      step();
      fence = 1'b1;
      step();
      checks++; if ({stall, fence_done} !== 2'b11) begin errors++; $display("FAIL empty_fence: got %b want 11", {stall, fence_done}); end
      step();
      checks++; if ({stall, fence_done} !== 2'b00) begin errors++; $display("FAIL empty_fence_after: got %b want 00", {stall, fence_done}); end
      fence = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      mem_ack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) begin
            memwrite = 2'b01; dataadr = 32'h300 + 32'(4 * i); writedata = 32'h5000 + 32'(i);
         end else begin
            memwrite = 2'b00;
         end
         #1;
         if (i > 0) begin
            checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300 + 32'(4 * (i - 1))) begin errors++; $display("FAIL b2b_%0d: got %b/%h want 1/%h", i, mem_req, mem_addr, 32'h300 + 32'(4 * (i - 1))); end
         end
         step();
      end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", mem_req); end
   endtask

`ifdef STBUF_FWD_EN
   task automatic test_forward();
      mem_ack = 1'b0; rd_addr = 32'h40;
      memwrite = 2'b01; dataadr = 32'h40; writedata = 32'h11;
      step();
      writedata = 32'h22;
      step();
      memwrite = 2'b00;
      #1;
      checks++; if ({rd_hit, rd_conflict} !== 2'b10 || rd_data !== 32'h22) begin errors++; $display("FAIL fwd_hit: got %b/%b/%h want 1/0/22", rd_hit, rd_conflict, rd_data); end
      rd_addr = 32'h44;
      #1;
      checks++; if ({rd_hit, rd_conflict} !== 2'b00) begin errors++; $display("FAIL fwd_miss: got %b/%b want 0/0", rd_hit, rd_conflict); end
      rd_addr = 32'h40; memwrite = 2'b11; dataadr = 32'h41; writedata = 32'h33;
      step();
      memwrite = 2'b00;
      #1;
      checks++; if ({rd_hit, rd_conflict} !== 2'b01) begin errors++; $display("FAIL fwd_conflict: got %b/%b want 0/1", rd_hit, rd_conflict); end
   endtask
`endif

   task automatic test_async_reset();
      mem_ack = 1'b0;
      memwrite = 2'b01; dataadr = 32'h500; writedata = 32'hCAFE;
      step();
      memwrite = 2'b00;
      #1;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL pre_reset_req: got %b want 1", mem_req); end
      reset = 1'b1;
      #1;
      checks++; if ({mem_req, mem_be, mem_addr, mem_wdata} !== 69'h0) begin errors++; $display("FAIL async_reset: got %b/%b/%h/%h want all 0", mem_req, mem_be, mem_addr, mem_wdata); end
`ifdef STBUF_FWD_EN
      checks++; if ({rd_hit, rd_conflict, rd_data} !== 34'h0) begin errors++; $display("FAIL async_reset_fwd: got %b/%b/%h want 0", rd_hit, rd_conflict, rd_data); end
`endif
      step();
      reset = 1'b0;
      step();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL post_reset_req: got %b want 0", mem_req); end
   endtask

   initial begin
      reset = 1'b1; memwrite = 2'b00; dataadr = '0; writedata = '0; fence = 1'b0; mem_ack = 1'b0;
`ifdef STBUF_FWD_EN
      rd_addr = '0;
`endif
      test_reset();
      test_word_store();
      test_sizes();
      test_full();
      test_misalign();
      test_fence();
      test_back_to_back();
`ifdef STBUF_FWD_EN
      test_forward();
`endif
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the single-cycle MIPS core's data port (`memwrite`, `dataadr`, `writedata`) and a data memory that may take several cycles per write. Each core store is captured in one cycle into a small in-order FIFO and drained to memory with a req/ack handshake, so the core stalls only when the buffer is full or during a fence. Optional store-to-load forwarding lets loads see buffered data before it reaches memory.

## Interface
- `DEPTH`, 4: number of buffer entries; power of two, minimum 2.
- `AW`, 32: address width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `memwrite`  in  2  store request from the core: 00 none, 01 word, 10 halfword, 11 byte.
- `dataadr`  in  AW  store byte address.
- `writedata`  in  32  store data, right-aligned: halfword in [15:0], byte in [7:0].
- `fence`  in  1  level; the core holds it high until `fence_done`.
- `stall`  out  1  core must hold its current instruction this cycle.
- `misalign`  out  1  one-cycle pulse, registered: the previous cycle's store was misaligned and was dropped.
- `fence_done`  out  1  one-cycle pulse: the fence completed.
- `mem_req`  out  1  head entry valid toward memory.
- `mem_addr`  out  AW  head address.
- `mem_wdata`  out  32  head data, lane-replicated: byte in all four lanes, halfword in both halves.
- `mem_be`  out  4  head byte enables, little-endian, derived from size and `addr[1:0]`.
- `mem_ack`  in  1  memory accepted the head this cycle.
- `rd_addr`  in  AW  load address (STBUF_FWD_EN only).
- `rd_hit`, `rd_data`, `rd_conflict`  out  1/32/1  forwarding results (STBUF_FWD_EN only).

## Operation
- Push when `memwrite != 0`, the address is aligned, `count < DEPTH`, and the FSM is in RUN.
- Alignment rules: a word store requires `addr[1:0] == 0`; a halfword store requires `addr[0] == 0`; a byte store is always aligned.
- A misaligned store is never pushed and never stalls; `misalign` pulses on the following cycle.
- Pop on `mem_req && mem_ack`. The FIFO is strictly in-order with no coalescing.
- The head outputs are driven directly from the head entry.
- `mem_req = (count != 0)`. Head fields are stable while `mem_req` is high and `mem_ack` is low.
- `stall` is combinational:
  - `(memwrite != 0) && aligned && count == DEPTH`, or
  - the FSM is in FENCE.
- A full buffer has no push bypass. If a push and a pop occur together when full, only the pop happens; the store is pushed on the next cycle while the core holds it.
- When not full, a simultaneous push and pop leave `count` unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - RUN: normal operation. When `fence` is high, go to FENCE.
  - FENCE: `stall` is high and pushes are blocked. When `count == 0`, pulse `fence_done` and go to DONE.
  - DONE: `stall` is low. Return to RUN when `fence` is low.
- A fence issued while the buffer is already empty spends one cycle in FENCE, then completes.
- Reset state: `count = 0`, pointers 0, FSM in RUN.
- Reset values: `stall`, `misalign`, `fence_done`, `mem_req`, `mem_be`, `rd_hit`, `rd_conflict` are all 0; `mem_addr`, `mem_wdata`, `rd_data` are 0.
- Reset asserted mid-drain discards every buffered entry; the memory side sees `mem_req` fall asynchronously.

## Timing
- A store accepted at edge N appears on `mem_req` in the cycle after edge N, provided the buffer was empty.
- Sustained throughput is one store per cycle with `mem_ack` tied high.
- `misalign` is high for exactly the cycle after the offending store's edge.
- `fence_done` is high for exactly one cycle.

## Configuration
- Macro `STBUF_FWD_EN` enables forwarding.
- When defined, a combinational search runs over valid entries from newest to oldest for word-address matches (`addr[AW-1:2]`). Only the youngest match counts:
  - Youngest match is a word store: `rd_hit = 1` and `rd_data` = its data.
  - Youngest match is a halfword or byte store: `rd_conflict = 1` and `rd_hit = 0`. The core stalls the load until the entry drains.
- When not defined, the `rd_*` ports are absent and no comparators are built.

## Structure
- Shared package `stbuf_pkg` holds:
  - the `memwrite` encoding enum (`ST_NONE`, `ST_WORD`, `ST_HALF`, `ST_BYTE`);
  - the FSM state enum;
  - the `stbuf_entry_t` struct (addr, data, size);
  - functions `be_gen(size, addr[1:0])` and `lane_rep(size, data)`.
- Sub-module `stbuf_fifo` is the generic entry FIFO: push/pop, full/empty, and a flattened entry view for the forwarding search.

## Test plan
- Word store 0xFFFF7F02 to address 84 with `mem_ack` high → next cycle `mem_req = 1`, `mem_addr = 84`, `mem_be = 1111`, `mem_wdata = FFFF7F02`; popped that cycle.
- Byte store 0x5A to address 0x13 → `mem_be = 1000`, `mem_wdata = 5A5A5A5A`. Halfword store 0x1234 to 0x22 → `mem_be = 1100`, `mem_wdata = 12341234`.
- With `mem_ack` low, issue 5 word stores (DEPTH = 4):
  - `stall` goes high on the 5th store;
  - one `mem_ack` pulse → the 5th store is pushed the next cycle;
  - entries drain in issue order.
- Word store to address 0x42 → nothing is pushed, `stall` stays 0, `misalign = 1` for one cycle.
- Three stores buffered, then `fence` raised; ack once every 3 cycles → `stall` stays high until `count = 0`, then `fence_done` pulses once.
- STBUF_FWD_EN builds:
  - word stores 0x11 then 0x22 to address 0x40 → `rd_addr = 0x40` gives `rd_hit = 1`, `rd_data = 0x22`;
  - a following byte store to 0x41 → `rd_conflict = 1`;
  - reset asserted mid-way → all outputs 0 immediately.
